// File: rtl/mem_bridge_if.sv
// Control-side strobe bundle and word-wide memory bus seen by mem_bridge.
// slave is the bridge's view; master is the control FSM plus memory slave.
interface mem_bridge_if;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [1:0]  mem_size;
   logic        mem_unsigned;
   logic        mem_resp;
   logic [31:0] mem_rdata;
   logic        mem_err;
   logic        busy;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport slave (
      input  mem_read, mem_write, mem_addr, mem_wdata, mem_size, mem_unsigned,
      output mem_resp, mem_rdata, mem_err, busy,
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_ack, bus_rdata
   );

   modport master (
      output mem_read, mem_write, mem_addr, mem_wdata, mem_size, mem_unsigned,
      input  mem_resp, mem_rdata, mem_err, busy,
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/mem_bridge.sv
// Turns one-cycle control strobes into a held req/ack word-bus transaction,
// with lane steering, load extension, misalignment and timeout detection.
module mem_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic         clk,
   input logic         rst,
   mem_bridge_if.slave io
);
   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUS  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   logic [1:0]       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [1:0]       r_off, w_off_nxt;
   logic [1:0]       r_size, w_size_nxt;
   logic             r_uns, w_uns_nxt;
   logic             r_req, w_req_nxt;
   logic             r_we, w_we_nxt;
   logic [31:0]      r_addr, w_addr_nxt;
   logic [3:0]       r_be, w_be_nxt;
   logic [31:0]      r_wdata, w_wdata_nxt;
   logic             r_resp, w_resp_nxt;
   logic             r_err, w_err_nxt;
   logic             r_busy, w_busy_nxt;
   logic [31:0]      r_rdata, w_rdata_nxt;

   logic             w_strobe;
   logic             w_legal;
   logic [3:0]       w_be;
   logic [31:0]      w_wdata;
   logic [15:0]      w_lane;
   logic [31:0]      w_ext;

   assign w_strobe = io.mem_read | io.mem_write;

   // Alignment / size legality of the incoming request
   always_comb begin
      w_legal = 1'b0;
      if (!(io.mem_read && io.mem_write)) begin
         case (io.mem_size)
            SZ_B:    w_legal = 1'b1;
            SZ_H:    w_legal = ~io.mem_addr[0];
            SZ_W:    w_legal = (io.mem_addr[1:0] == 2'b00);
            default: w_legal = 1'b0;
         endcase
      end
   end

   // Byte enables and lane-replicated store data
   always_comb begin
      case (io.mem_size)
         SZ_B: begin
            w_be    = 4'b0001 << io.mem_addr[1:0];
            w_wdata = {4{io.mem_wdata[7:0]}};
         end
         SZ_H: begin
            w_be    = 4'b0011 << io.mem_addr[1:0];
            w_wdata = {2{io.mem_wdata[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = io.mem_wdata;
         end
      endcase
   end

   // Halfword accesses are aligned, so the byte-offset shift also selects the half
   assign w_lane = 16'(io.bus_rdata >> {r_off, 3'b000});

   always_comb begin
      case (r_size)
         SZ_B:    w_ext = {{24{~r_uns & w_lane[7]}}, w_lane[7:0]};
         SZ_H:    w_ext = {{16{~r_uns & w_lane[15]}}, w_lane[15:0]};
         default: w_ext = io.bus_rdata;
      endcase
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_off_nxt   = r_off;
      w_size_nxt  = r_size;
      w_uns_nxt   = r_uns;
      w_req_nxt   = r_req;
      w_we_nxt    = r_we;
      w_addr_nxt  = r_addr;
      w_be_nxt    = r_be;
      w_wdata_nxt = r_wdata;
      w_resp_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      w_rdata_nxt = r_rdata;

      case (r_state)
         S_IDLE: begin
            if (w_strobe) begin
               if (w_legal) begin
                  w_state_nxt = S_BUS;
                  w_req_nxt   = 1'b1;
                  w_cnt_nxt   = '0;
                  w_we_nxt    = io.mem_write;
                  w_addr_nxt  = {io.mem_addr[31:2], 2'b00};
                  w_off_nxt   = io.mem_addr[1:0];
                  w_size_nxt  = io.mem_size;
                  w_uns_nxt   = io.mem_unsigned;
                  w_be_nxt    = w_be;
                  w_wdata_nxt = w_wdata;
               end else begin
                  w_state_nxt = S_RESP;
                  w_resp_nxt  = 1'b1;
                  w_err_nxt   = 1'b1;
                  if (io.mem_read) w_rdata_nxt = '0;
               end
            end
         end
         S_BUS: begin
            // Ack is checked first so it wins over a coincident timeout
            if (io.bus_ack) begin
               w_state_nxt = S_RESP;
               w_req_nxt   = 1'b0;
               w_resp_nxt  = 1'b1;
               if (!r_we) w_rdata_nxt = w_ext;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = S_RESP;
               w_req_nxt   = 1'b0;
               w_resp_nxt  = 1'b1;
               w_err_nxt   = 1'b1;
               if (!r_we) w_rdata_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_req_nxt   = 1'b0;
         end
      endcase

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_off   <= '0;
         r_size  <= '0;
         r_uns   <= 1'b0;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_be    <= '0;
         r_wdata <= '0;
         r_resp  <= 1'b0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_off   <= w_off_nxt;
         r_size  <= w_size_nxt;
         r_uns   <= w_uns_nxt;
         r_req   <= w_req_nxt;
         r_we    <= w_we_nxt;
         r_addr  <= w_addr_nxt;
         r_be    <= w_be_nxt;
         r_wdata <= w_wdata_nxt;
         r_resp  <= w_resp_nxt;
         r_err   <= w_err_nxt;
         r_busy  <= w_busy_nxt;
         r_rdata <= w_rdata_nxt;
      end
   end

   assign io.bus_req   = r_req;
   assign io.bus_we    = r_we;
   assign io.bus_addr  = r_addr;
   assign io.bus_be    = r_be;
   assign io.bus_wdata = r_wdata;
   assign io.mem_resp  = r_resp;
   assign io.mem_err   = r_err;
   assign io.busy      = r_busy;
   assign io.mem_rdata = r_rdata;
endmodule

// File: tb/tb_mem_bridge.sv
// Bench for mem_bridge: directed vector table, reset/busy sequences and
// randomized accesses checked against an arithmetic reference model.
module tb_mem_bridge;
   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   logic [31:0] m_rdata = '0;

   mem_bridge_if bif ();

   mem_bridge #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .io(bif));

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        uns;
      int          d;
      logic [31:0] brd;
      logic        legal;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic        e_err;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model, written straight from the access rules
   function automatic logic m_legal(input logic rd, input logic wr, input logic [1:0] size,
                                    input logic [31:0] addr);
      int unsigned a = addr % 4;
      if (rd && wr) return 1'b0;
      if (size == 2'd0) return 1'b1;
      if (size == 2'd1) return (a % 2) == 0;
      if (size == 2'd2) return a == 0;
      return 1'b0;
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
      int unsigned a = addr % 4;
      if (size == 2'd0) return 4'(1 << a);
      if (size == 2'd1) return 4'(3 << a);
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wd(input logic [1:0] size, input logic [31:0] wd);
      int unsigned w = wd;
      if (size == 2'd0) return 32'((w % 256) * 32'h0101_0101);
      if (size == 2'd1) return 32'((w % 65536) * 32'h0001_0001);
      return wd;
   endfunction

   function automatic logic [31:0] m_ext(input logic [1:0] size, input logic [31:0] addr,
                                         input logic uns, input logic [31:0] word);
      int unsigned w = word;
      int unsigned a = addr % 4;
      int unsigned v;
      if (size == 2'd0) begin
         v = (w >> (8 * a)) % 256;
         if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
         return v;
      end
      if (size == 2'd1) begin
         v = (w >> (16 * (a / 2))) % 65536;
         if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
         return v;
      end
      return word;
   endfunction

   // One full access: strobe, optional ack after d cycles (d < 0: never), checks
   task automatic run_acc(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns, input int d,
                          input logic [31:0] brd, input logic legal,
                          input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic [31:0] e_wdata, input logic e_err,
                          input logic [31:0] e_rdata);
      int resp_c = 0;
      int reqs = 0;
      int exp_resp_c;
      int exp_reqs;
      bit ok;
      logic [31:0] a0 = '0;
      logic [3:0]  be0 = '0;
      logic [31:0] wd0 = '0;
      logic        we0 = 1'b0;
      logic        stable = 1'b1;
      ok = legal && d >= 0 && d < TO;
      exp_resp_c = !legal ? 1 : (ok ? d + 2 : TO + 1);
      exp_reqs   = !legal ? 0 : (ok ? d + 1 : TO);
      @(negedge clk);
      bif.mem_read = rd;   bif.mem_write = wr;  bif.mem_addr = addr;
      bif.mem_wdata = wdata; bif.mem_size = size; bif.mem_unsigned = uns;
      bif.bus_rdata = brd;
      for (int c = 1; c <= 20 && resp_c == 0; c++) begin
         @(negedge clk);
         if (c == 1) begin
            bif.mem_read = 1'b0;
            bif.mem_write = 1'b0;
         end
         if (bif.bus_req) begin
            reqs++;
            if (reqs == 1) begin
               a0 = bif.bus_addr; be0 = bif.bus_be; wd0 = bif.bus_wdata; we0 = bif.bus_we;
            end else if (a0 !== bif.bus_addr || be0 !== bif.bus_be ||
                         wd0 !== bif.bus_wdata || we0 !== bif.bus_we) begin
               stable = 1'b0;
            end
         end
         if (bif.mem_resp) begin
            resp_c = c;
            chk($sformatf("%s.err", tag), 32'(bif.mem_err), 32'(e_err));
            chk($sformatf("%s.rdata", tag), bif.mem_rdata, e_rdata);
            chk($sformatf("%s.busy_resp", tag), 32'(bif.busy), 32'd1);
         end
         bif.bus_ack = bif.bus_req && d >= 0 && (c - 1) == d;
      end
      bif.bus_ack = 1'b0;
      chk($sformatf("%s.resp_cycle", tag), 32'(resp_c), 32'(exp_resp_c));
      chk($sformatf("%s.req_cycles", tag), 32'(reqs), 32'(exp_reqs));
      if (legal) begin
         chk($sformatf("%s.bus_addr", tag), a0, e_addr);
         chk($sformatf("%s.bus_be", tag), 32'(be0), 32'(e_be));
         chk($sformatf("%s.bus_we", tag), 32'(we0), 32'(wr));
         chk($sformatf("%s.stable", tag), 32'(stable), 32'd1);
         if (wr) chk($sformatf("%s.bus_wdata", tag), wd0, e_wdata);
      end
      @(negedge clk);
      chk($sformatf("%s.resp_drop", tag), 32'(bif.mem_resp), 32'd0);
      chk($sformatf("%s.busy_drop", tag), 32'(bif.busy), 32'd0);
      chk($sformatf("%s.rdata_hold", tag), bif.mem_rdata, e_rdata);
   endtask

   initial begin
      int nresp;
      bif.mem_read = 1'b0; bif.mem_write = 1'b0; bif.mem_addr = '0; bif.mem_wdata = '0;
      bif.mem_size = '0; bif.mem_unsigned = 1'b0; bif.bus_ack = 1'b0; bif.bus_rdata = '0;

      tbl[0]  = '{"w_rd_100", 1, 0, 32'h100, 0, 2, 0, 3, 32'hCAFEF00D, 1, 32'h100, 4'hF, 0, 0, 32'hCAFEF00D};
      tbl[1]  = '{"b_rd_s",   1, 0, 32'h103, 0, 0, 0, 0, 32'h80123456, 1, 32'h100, 4'h8, 0, 0, 32'hFFFFFF80};
      tbl[2]  = '{"b_rd_u",   1, 0, 32'h103, 0, 0, 1, 0, 32'h80123456, 1, 32'h100, 4'h8, 0, 0, 32'h00000080};
      tbl[3]  = '{"h_wr_202", 0, 1, 32'h202, 32'h0000BEEF, 1, 0, 1, 0, 1, 32'h200, 4'hC, 32'hBEEFBEEF, 0, 32'h00000080};
      tbl[4]  = '{"w_rd_101", 1, 0, 32'h101, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      tbl[5]  = '{"timeout",  1, 0, 32'h200, 0, 2, 0, -1, 0, 1, 32'h200, 4'hF, 0, 1, 0};
      tbl[6]  = '{"h_rd_u",   1, 0, 32'h002, 0, 1, 1, 0, 32'h80011234, 1, 0, 4'hC, 0, 0, 32'h00008001};
      tbl[7]  = '{"h_rd_s",   1, 0, 32'h002, 0, 1, 0, 2, 32'h80011234, 1, 0, 4'hC, 0, 0, 32'hFFFF8001};
      tbl[8]  = '{"b_wr_1",   0, 1, 32'h001, 32'h123456AB, 0, 0, 2, 0, 1, 0, 4'h2, 32'hABABABAB, 0, 32'hFFFF8001};
      tbl[9]  = '{"sz11",     1, 0, 32'h000, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      tbl[10] = '{"both",     1, 1, 32'h000, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      tbl[11] = '{"h_mis",    1, 0, 32'h001, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};

      repeat (2) @(negedge clk);
      chk("rst.bus_req", 32'(bif.bus_req), 0);
      chk("rst.bus_we", 32'(bif.bus_we), 0);
      chk("rst.mem_resp", 32'(bif.mem_resp), 0);
      chk("rst.mem_err", 32'(bif.mem_err), 0);
      chk("rst.busy", 32'(bif.busy), 0);
      chk("rst.bus_addr", bif.bus_addr, 0);
      chk("rst.bus_be", 32'(bif.bus_be), 0);
      chk("rst.bus_wdata", bif.bus_wdata, 0);
      chk("rst.mem_rdata", bif.mem_rdata, 0);
      rst = 1'b0;

      foreach (tbl[i])
         run_acc(tbl[i].tag, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].size,
                 tbl[i].uns, tbl[i].d, tbl[i].brd, tbl[i].legal, tbl[i].e_addr, tbl[i].e_be,
                 tbl[i].e_wdata, tbl[i].e_err, tbl[i].e_rdata);

      // Reset in the middle of a bus transaction
      @(negedge clk);
      bif.mem_read = 1'b1; bif.mem_addr = 32'h40; bif.mem_size = 2'd2;
      @(negedge clk);
      bif.mem_read = 1'b0;
      chk("mid_rst.req_before", 32'(bif.bus_req), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst.req_drop", 32'(bif.bus_req), 0);
      chk("mid_rst.busy_drop", 32'(bif.busy), 0);
      @(negedge clk);
      rst = 1'b0;
      nresp = 0;
      repeat (6) begin
         @(negedge clk);
         if (bif.mem_resp) nresp++;
      end
      chk("mid_rst.no_resp", 32'(nresp), 0);
      run_acc("post_rst", 1, 0, 32'h44, 0, 2, 0, 0, 32'h13579BDF, 1, 32'h44, 4'hF, 0, 0, 32'h13579BDF);

      // A write strobe while busy is dropped; only the read responds
      @(negedge clk);
      bif.mem_read = 1'b1; bif.mem_addr = 32'h300; bif.mem_size = 2'd2;
      bif.bus_rdata = 32'h2468ACE0;
      nresp = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (bif.mem_resp) nresp++;
         if (c == 2) chk("busy_strobe.we", 32'(bif.bus_we), 0);
         bif.mem_read  = 1'b0;
         bif.mem_write = (c == 1);
         bif.mem_addr  = (c == 1) ? 32'h310 : 32'h300;
         bif.bus_ack   = bif.bus_req && c == 3;
      end
      bif.mem_write = 1'b0;
      bif.bus_ack = 1'b0;
      chk("busy_strobe.resp_count", 32'(nresp), 1);
      chk("busy_strobe.rdata", bif.mem_rdata, 32'h2468ACE0);
      m_rdata = 32'h2468ACE0;

      // Randomized accesses against the model
      for (int i = 0; i < 60; i++) begin
         logic rd, wr, uns, lg;
         logic [31:0] addr, wd, brd, erd;
         logic [1:0] size;
         int r, d;
         r = int'($urandom_range(0, 9));
         rd = (r < 5) || (r == 9);
         wr = (r >= 5);
         addr = $urandom;
         if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
         size = 2'($urandom_range(0, 3));
         uns = 1'($urandom_range(0, 1));
         wd = $urandom;
         brd = $urandom;
         d = int'($urandom_range(0, 5));
         lg = m_legal(rd, wr, size, addr);
         if (rd) erd = (lg && d < TO) ? m_ext(size, addr, uns, brd) : 32'h0;
         else    erd = m_rdata;
         run_acc($sformatf("rnd%0d", i), rd, wr, addr, wd, size, uns, d, brd, lg,
                 {addr[31:2], 2'b00}, m_be(size, addr), m_wd(size, wd),
                 !(lg && d < TO), erd);
         m_rdata = erd;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Sits directly downstream of the multi-cycle control FSM. Converts its single-cycle mem_read/mem_write strobes plus MAR/MDR values into a held request/acknowledge transaction on the word-wide memory bus.
- Performs byte/halfword lane steering and load sign/zero extension.
- Returns a one-cycle mem_resp pulse, which the FSM waits on in its FETCH_1, LD_2 and ST_3 states.
- Detects misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles bus_req may stay high without bus_ack before the access is aborted. Legal range 1..65535.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- mem_read  in  1  one-cycle read strobe from control.
- mem_write  in  1  one-cycle write strobe from control.
- mem_addr  in  32  byte address (MAR).
- mem_wdata  in  32  store data (MDR); the value is in the low bits for byte/half stores.
- mem_size  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- mem_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend loads.
- mem_resp  out  1  one-cycle completion pulse.
- mem_rdata  out  32  extended load data; valid from the mem_resp cycle and held until the next accepted read.
- mem_err  out  1  asserted together with mem_resp when the access failed (misaligned, illegal size, or timeout).
- busy  out  1  high from the cycle after a request is accepted up to and including the mem_resp cycle.
- bus_req  out  1  bus request, held until bus_ack.
- bus_we  out  1  bus write enable.
- bus_addr  out  32  word-aligned address; bits [1:0] are always 00.
- bus_be  out  4  byte enables. Also driven on reads; the slave may ignore them there.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  slave acknowledge; read data is valid in the same cycle.
- bus_rdata  in  32  word read data.

Behaviour:
- Reset (async, rst = 1):
  - State goes to IDLE.
  - bus_req, bus_we, mem_resp, mem_err and busy are all 0.
  - bus_addr, bus_be, bus_wdata and mem_rdata are all 0.
  - Timeout counter is 0.
  - If reset is asserted mid-transaction, the transaction is abandoned: bus_req drops immediately and no mem_resp is produced.
- States:
  - IDLE → BUS when a strobe is sampled and the access is legal.
  - IDLE → RESP when a strobe is sampled and the access is illegal.
  - BUS → RESP on bus_ack or on timeout.
  - RESP → IDLE unconditionally.
- Acceptance:
  - A strobe is only sampled in IDLE; strobes in any other state are ignored (no queueing).
  - If mem_read and mem_write are high together, the request is treated as illegal: mem_err = 1 and no bus activity.
- Legality (misaligned or illegal-size accesses go straight to RESP with mem_err = 1):
  - Byte: always legal.
  - Half: legal only if mem_addr[0] = 0.
  - Word: legal only if mem_addr[1:0] = 00.
  - Size 11: illegal.
- Request registers, captured on the accept edge:
  - bus_addr = {mem_addr[31:2], 2'b00}.
  - bus_we = mem_write.
  - Byte offset = mem_addr[1:0].
  - mem_size and mem_unsigned are latched.
- Byte enables:
  - Byte: bus_be = 0001 shifted left by the offset.
  - Half: bus_be = 0011 shifted left by the offset.
  - Word: bus_be = 1111.
- Write data:
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata unchanged.
- BUS state:
  - bus_req = 1 and all bus outputs are stable for the whole state.
  - The counter increments every cycle that bus_ack = 0.
  - On bus_ack, read data is captured on that edge.
  - If the counter reaches TIMEOUT_CYCLES, bus_req drops and the FSM enters RESP with mem_err = 1.
  - If bus_ack arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the ack wins.
- Read extraction:
  - Byte: select the lane by offset, then extend from bit 7.
  - Half: select lane [15:0] or [31:16] by offset[1], then extend from bit 15.
  - Word: pass through unchanged.
  - Failed reads load mem_rdata = 0.
  - Writes leave mem_rdata unchanged.
- RESP state:
  - mem_resp = 1 for exactly one cycle; mem_err is valid in the same cycle.
  - bus_req = 0.
- Latency:
  - Strobe sampled at edge T → bus_req high in cycle T+1.
  - Ack in cycle T+1+k → mem_resp in cycle T+2+k.
  - Minimum is 2 cycles after the strobe.
  - An illegal access gives mem_resp in cycle T+1.
- Back-to-back: a new strobe is accepted in the first IDLE cycle after RESP. The control FSM needs ≥1 idle cycle between responses, so none are lost.

Test Plan:
- Word read at 0x100, bus_ack 3 cycles after bus_req with bus_rdata = 0xCAFEF00D:
  - Required: bus_addr = 0x100 and bus_be = 1111.
  - Required: mem_resp one cycle after the ack, mem_rdata = 0xCAFEF00D held afterwards, mem_err = 0.
- Byte reads at 0x103, bus_rdata = 0x80123456:
  - Signed read → mem_rdata = 0xFFFFFF80 and bus_be = 1000.
  - Unsigned read → mem_rdata = 0x00000080.
- Half write at 0x202 with wdata = 0x0000BEEF:
  - Required: bus_addr = 0x200, bus_be = 1100, bus_wdata = 0xBEEFBEEF, bus_we = 1.
  - Required: mem_resp after the ack, mem_rdata unchanged.
- Word read at 0x101:
  - Required: no bus_req, mem_resp and mem_err = 1 in the next cycle, mem_rdata = 0.
- TIMEOUT_CYCLES = 4, bus_ack tied to 0:
  - Required: bus_req high for 4 cycles, then drops; mem_resp with mem_err = 1 follows.
  - Required: a following read with a prompt ack completes normally.
- Reset mid-BUS:
  - Assert rst while bus_req = 1 → bus_req = 0 immediately and no mem_resp.
  - After rst is released, a new read is accepted.
  - A strobe issued while busy is ignored, giving exactly one mem_resp.
